// File: rtl/obi_pkg.sv
// Shared OBI widths and the packed request word layout used by the request-side
// buffering slices.
package obi_pkg;

    localparam int OBI_ADDR_W = 32;
    localparam int OBI_DATA_W = 32;
    localparam int OBI_BE_W   = 4;
    localparam int OBI_REQ_W  = OBI_ADDR_W + 1 + OBI_BE_W + OBI_DATA_W;

    // Bit offsets inside the packed request word, wdata in the LSBs.
    localparam int OBI_WDATA_LSB = 0;
    localparam int OBI_BE_LSB    = OBI_WDATA_LSB + OBI_DATA_W;
    localparam int OBI_WE_BIT    = OBI_BE_LSB + OBI_BE_W;
    localparam int OBI_ADDR_LSB  = OBI_WE_BIT + 1;

    typedef struct packed {
        logic [OBI_ADDR_W-1:0] addr;
        logic                  we;
        logic [OBI_BE_W-1:0]   be;
        logic [OBI_DATA_W-1:0] wdata;
    } obi_req_t;

    function automatic obi_req_t obi_req_pack(
        input logic [OBI_ADDR_W-1:0] addr,
        input logic                  we,
        input logic [OBI_BE_W-1:0]   be,
        input logic [OBI_DATA_W-1:0] wdata
    );
        obi_req_t req;
        req.addr  = addr;
        req.we    = we;
        req.be    = be;
        req.wdata = wdata;
        return req;
    endfunction

endpackage

// File: rtl/obi_sync_fifo.sv
// Single-clock FIFO with occupancy count; push is ignored when full and pop is
// ignored when empty, so callers may drive them unqualified.
module obi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_reg == CW'(DEPTH));
    assign empty_o = (count_reg == '0);
    assign count_o = count_reg;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Head is read straight from storage so it is valid in the same cycle the
    // registered count says the FIFO is non-empty.
    assign rdata_o = mem[rd_ptr_reg];

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata_i;
        end
    end

endmodule

// File: rtl/obi_req_buffer.sv
// Controller-side OBI request buffer feeding the fast-primary CDC: queues requests,
// caps in-flight transactions and registers the response path.
module obi_req_buffer
    import obi_pkg::*;
#(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ctrl_req_i,
    output logic                  ctrl_gnt_o,
    input  logic [OBI_ADDR_W-1:0] ctrl_addr_i,
    input  logic                  ctrl_we_i,
    input  logic [OBI_BE_W-1:0]   ctrl_be_i,
    input  logic [OBI_DATA_W-1:0] ctrl_wdata_i,
    output logic                  ctrl_rvalid_o,
    output logic [OBI_DATA_W-1:0] ctrl_rdata_o,
    output logic                  secondary_req_o,
    input  logic                  secondary_gnt_i,
    output logic [OBI_ADDR_W-1:0] secondary_addr_o,
    output logic                  secondary_we_o,
    output logic [OBI_BE_W-1:0]   secondary_be_o,
    output logic [OBI_DATA_W-1:0] secondary_wdata_o,
    input  logic                  secondary_rvalid_i,
    input  logic [OBI_DATA_W-1:0] secondary_rdata_i
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("obi_req_buffer: DEPTH must be a power of two and at least 2");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15) begin : g_bad_max
        $error("obi_req_buffer: MAX_OUTSTANDING must be within 1..15");
    end

    obi_req_t         push_req;
    obi_req_t         head_req;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [3:0]       outstanding_reg;
    logic [3:0]       outstanding_next;
    logic             do_push;
    logic             do_pop;

    // Grant is a pure function of registered occupancy so it never forms a
    // combinational path from the controller request or the downstream grant.
    assign ctrl_gnt_o = !fifo_full &&
                        ((int'(fifo_count) + int'(outstanding_reg)) < MAX_OUTSTANDING);
    assign do_push    = ctrl_req_i && ctrl_gnt_o;
    assign push_req   = obi_req_pack(ctrl_addr_i, ctrl_we_i, ctrl_be_i, ctrl_wdata_i);

    obi_sync_fifo #(
        .WIDTH (OBI_REQ_W),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (do_push),
        .wdata_i (push_req),
        .pop_i   (do_pop),
        .rdata_o (head_req),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // The head entry only changes on a pop, which keeps the payload stable
    // for as long as the request waits for a grant.
    assign secondary_req_o   = !fifo_empty;
    assign secondary_addr_o  = head_req.addr;
    assign secondary_we_o    = head_req.we;
    assign secondary_be_o    = head_req.be;
    assign secondary_wdata_o = head_req.wdata;
    assign do_pop            = secondary_req_o && secondary_gnt_i;

    always_comb begin
        outstanding_next = outstanding_reg;
        case ({do_pop, secondary_rvalid_i})
            2'b10: outstanding_next = outstanding_reg + 4'd1;
            2'b01: begin
                // A stray response must not wrap the counter and wedge the grant.
                if (outstanding_reg != 4'd0) begin
                    outstanding_next = outstanding_reg - 4'd1;
                end
            end
            default: outstanding_next = outstanding_reg;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_reg <= 4'd0;
            ctrl_rvalid_o   <= 1'b0;
            ctrl_rdata_o    <= '0;
        end else begin
            outstanding_reg <= outstanding_next;
            ctrl_rvalid_o   <= secondary_rvalid_i;
            if (secondary_rvalid_i) begin
                ctrl_rdata_o <= secondary_rdata_i;
            end
        end
    end

    rvalid_needs_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(secondary_rvalid_i && outstanding_reg == 4'd0))
        else $warning("obi_req_buffer: response arrived with no transaction outstanding");

    occupancy_within_cap: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (int'(fifo_count) + int'(outstanding_reg)) <= MAX_OUTSTANDING)
        else $error("obi_req_buffer: queued plus issued transactions exceed the cap");

endmodule

// File: tb/tb_obi_req_buffer.sv
// Directed bench for obi_req_buffer: reset, single write, backpressure, cap,
// simultaneous events, pointer wrap, stray response and mid-burst reset.
module tb_obi_req_buffer;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        rst_ni;
    logic        ctrl_req, ctrl_we;
    logic [31:0] ctrl_addr, ctrl_wdata;
    logic [3:0]  ctrl_be;
    logic        sec_gnt, sec_rvalid;
    logic [31:0] sec_rdata;
    logic        req2, sec_gnt2, sec_rvalid2;

    logic        ctrl_gnt, ctrl_rvalid, sec_req, sec_we;
    logic [31:0] ctrl_rdata, sec_addr, sec_wdata;
    logic [3:0]  sec_be;
    logic        ctrl_gnt2, ctrl_rvalid2, sec_req2, sec_we2;
    logic [31:0] ctrl_rdata2, sec_addr2, sec_wdata2;
    logic [3:0]  sec_be2;

    int checks = 0;
    int errors = 0;
    int pushed, popped, pend;
    logic [31:0] exp_q [$];

    obi_req_buffer #(.DEPTH(4), .MAX_OUTSTANDING(4)) u_dut (
        .clk_i (clk_i), .rst_ni (rst_ni),
        .ctrl_req_i (ctrl_req), .ctrl_gnt_o (ctrl_gnt),
        .ctrl_addr_i (ctrl_addr), .ctrl_we_i (ctrl_we), .ctrl_be_i (ctrl_be),
        .ctrl_wdata_i (ctrl_wdata), .ctrl_rvalid_o (ctrl_rvalid), .ctrl_rdata_o (ctrl_rdata),
        .secondary_req_o (sec_req), .secondary_gnt_i (sec_gnt),
        .secondary_addr_o (sec_addr), .secondary_we_o (sec_we), .secondary_be_o (sec_be),
        .secondary_wdata_o (sec_wdata), .secondary_rvalid_i (sec_rvalid),
        .secondary_rdata_i (sec_rdata)
    );

    obi_req_buffer #(.DEPTH(4), .MAX_OUTSTANDING(2)) u_dut_cap2 (
        .clk_i (clk_i), .rst_ni (rst_ni),
        .ctrl_req_i (req2), .ctrl_gnt_o (ctrl_gnt2),
        .ctrl_addr_i (ctrl_addr), .ctrl_we_i (ctrl_we), .ctrl_be_i (ctrl_be),
        .ctrl_wdata_i (ctrl_wdata), .ctrl_rvalid_o (ctrl_rvalid2), .ctrl_rdata_o (ctrl_rdata2),
        .secondary_req_o (sec_req2), .secondary_gnt_i (sec_gnt2),
        .secondary_addr_o (sec_addr2), .secondary_we_o (sec_we2), .secondary_be_o (sec_be2),
        .secondary_wdata_o (sec_wdata2), .secondary_rvalid_i (sec_rvalid2),
        .secondary_rdata_i (sec_rdata)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        ctrl_req = 0; ctrl_we = 0; ctrl_addr = 0; ctrl_wdata = 0; ctrl_be = 0;
        sec_gnt = 0; sec_rvalid = 0; sec_rdata = 0;
        req2 = 0; sec_gnt2 = 0; sec_rvalid2 = 0;

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            ctrl_req = 1'($urandom); ctrl_we = 1'($urandom); ctrl_addr = $urandom;
            ctrl_be = 4'($urandom); ctrl_wdata = $urandom; sec_gnt = 1'($urandom);
            sec_rvalid = 1'($urandom); sec_rdata = $urandom;
            req2 = 1'($urandom); sec_gnt2 = 1'($urandom); sec_rvalid2 = 1'($urandom);
            tick();
            chk("rst_rvalid", 32'(ctrl_rvalid), 0);
            chk("rst_rdata", ctrl_rdata, 0);
            chk("rst_req", 32'(sec_req), 0);
            chk("rst_req2", 32'(sec_req2), 0);
        end
        ctrl_req = 0; ctrl_we = 0; ctrl_addr = 0; ctrl_be = 0; ctrl_wdata = 0;
        sec_gnt = 0; sec_rvalid = 0; sec_rdata = 0;
        req2 = 0; sec_gnt2 = 0; sec_rvalid2 = 0;
        rst_ni = 1'b1;
        tick();
        chk("post_rst_gnt", 32'(ctrl_gnt), 1);
        chk("post_rst_gnt2", 32'(ctrl_gnt2), 1);
        chk("post_rst_req", 32'(sec_req), 0);
        chk("post_rst_rvalid", 32'(ctrl_rvalid), 0);

        // Single write, downstream always granting
        ctrl_req = 1; ctrl_we = 1; ctrl_addr = 32'h1000_0010; ctrl_be = 4'hF;
        ctrl_wdata = 32'hDEAD_BEEF; sec_gnt = 1;
        chk("wr_gnt", 32'(ctrl_gnt), 1);
        tick();
        ctrl_req = 0;
        chk("wr_req", 32'(sec_req), 1);
        chk("wr_addr", sec_addr, 32'h1000_0010);
        chk("wr_we", 32'(sec_we), 1);
        chk("wr_be", 32'(sec_be), 32'hF);
        chk("wr_wdata", sec_wdata, 32'hDEAD_BEEF);
        tick();
        chk("wr_req_drop", 32'(sec_req), 0);
        sec_rvalid = 1; sec_rdata = 32'h1234_5678;
        tick();
        sec_rvalid = 0;
        chk("wr_rvalid", 32'(ctrl_rvalid), 1);
        chk("wr_rdata", ctrl_rdata, 32'h1234_5678);
        tick();
        chk("wr_rvalid_drop", 32'(ctrl_rvalid), 0);
        chk("wr_rdata_hold", ctrl_rdata, 32'h1234_5678);

        // Backpressure: fill the FIFO with the downstream stalled
        sec_gnt = 0; ctrl_we = 0;
        for (int i = 0; i < 4; i++) begin
            ctrl_req = 1; ctrl_addr = 32'h2000_0000 + 32'(4 * i);
            chk("bp_gnt", 32'(ctrl_gnt), 1);
            tick();
        end
        ctrl_req = 0;
        chk("bp_full_gnt", 32'(ctrl_gnt), 0);
        chk("bp_req", 32'(sec_req), 1);
        chk("bp_head", sec_addr, 32'h2000_0000);
        tick();
        tick();
        chk("bp_head_hold", sec_addr, 32'h2000_0000);
        chk("bp_req_hold", 32'(sec_req), 1);
        sec_gnt = 1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_drain_req", 32'(sec_req), 1);
            chk("bp_drain_addr", sec_addr, 32'h2000_0000 + 32'(4 * i));
            tick();
        end
        sec_gnt = 0;
        chk("bp_empty_req", 32'(sec_req), 0);
        chk("cap4_gnt", 32'(ctrl_gnt), 0);
        for (int i = 0; i < 4; i++) begin
            sec_rvalid = 1; sec_rdata = 32'hB000_0000 + 32'(i);
            tick();
            chk("bp_rvalid", 32'(ctrl_rvalid), 1);
            chk("bp_rdata", ctrl_rdata, 32'hB000_0000 + 32'(i));
            if (i == 0) chk("cap4_release_gnt", 32'(ctrl_gnt), 1);
        end
        sec_rvalid = 0;
        tick();
        chk("bp_rvalid_drop", 32'(ctrl_rvalid), 0);
        chk("bp_idle_gnt", 32'(ctrl_gnt), 1);

        // Push and pop together at count=1, then pop and rvalid together
        ctrl_req = 1; ctrl_addr = 32'h0000_00A0;
        tick();
        ctrl_addr = 32'h0000_00A1; sec_gnt = 1;
        chk("sim_head0", sec_addr, 32'h0000_00A0);
        chk("sim_gnt", 32'(ctrl_gnt), 1);
        tick();
        ctrl_req = 0;
        chk("sim_req", 32'(sec_req), 1);
        chk("sim_head1", sec_addr, 32'h0000_00A1);
        sec_rvalid = 1; sec_rdata = 32'hCAFE_0001;
        tick();
        sec_rvalid = 0; sec_gnt = 0;
        chk("sim_req_drop", 32'(sec_req), 0);
        chk("sim_rvalid", 32'(ctrl_rvalid), 1);
        chk("sim_rdata", ctrl_rdata, 32'hCAFE_0001);
        // One transaction still outstanding: only three more may be queued
        for (int i = 0; i < 3; i++) begin
            ctrl_req = 1; ctrl_addr = 32'h0000_00D0 + 32'(i);
            chk("sim_fill_gnt", 32'(ctrl_gnt), 1);
            tick();
        end
        ctrl_req = 0;
        chk("sim_cap_gnt", 32'(ctrl_gnt), 0);
        sec_gnt = 1;
        for (int i = 0; i < 3; i++) tick();
        sec_gnt = 0;
        chk("sim_drain_req", 32'(sec_req), 0);
        chk("sim_drain_gnt", 32'(ctrl_gnt), 0);
        sec_rvalid = 1;
        for (int i = 0; i < 4; i++) tick();
        sec_rvalid = 0;
        chk("sim_idle_gnt", 32'(ctrl_gnt), 1);

        // Ten-request stream wrapping the pointers, responses returned in order
        pushed = 0; popped = 0; pend = 0; sec_gnt = 1;
        for (int cyc = 0; cyc < 200 && (popped < 10 || pend > 0); cyc++) begin
            ctrl_req = (pushed < 10);
            ctrl_addr = 32'hC000_0000 + 32'(pushed);
            sec_rvalid = (pend > 0);
            sec_rdata = 32'h7700_0000 + 32'(cyc);
            if (sec_req && sec_gnt) begin
                chk("wrap_addr", sec_addr, exp_q.pop_front());
                popped++;
                pend++;
            end
            if (ctrl_req && ctrl_gnt) begin
                exp_q.push_back(ctrl_addr);
                pushed++;
            end
            if (sec_rvalid) pend--;
            tick();
        end
        ctrl_req = 0; sec_rvalid = 0; sec_gnt = 0;
        chk("wrap_pushed", 32'(pushed), 10);
        chk("wrap_popped", 32'(popped), 10);
        tick();

        // Stray response with nothing outstanding
        sec_rvalid = 1; sec_rdata = 32'h5A5A_0001;
        tick();
        sec_rvalid = 0;
        chk("stray_rvalid", 32'(ctrl_rvalid), 1);
        chk("stray_rdata", ctrl_rdata, 32'h5A5A_0001);
        chk("stray_gnt", 32'(ctrl_gnt), 1);
        for (int i = 0; i < 4; i++) begin
            ctrl_req = 1; ctrl_addr = 32'h0000_00E0 + 32'(i);
            chk("stray_fill_gnt", 32'(ctrl_gnt), 1);
            tick();
        end
        ctrl_req = 0;
        chk("stray_full_gnt", 32'(ctrl_gnt), 0);
        chk("burst_req", 32'(sec_req), 1);

        // Reset in the middle of a queued burst
        #2;
        rst_ni = 1'b0;
        #1;
        chk("midrst_req", 32'(sec_req), 0);
        chk("midrst_rvalid", 32'(ctrl_rvalid), 0);
        tick();
        rst_ni = 1'b1; sec_gnt = 1;
        tick();
        tick();
        chk("midrst_req_after", 32'(sec_req), 0);
        chk("midrst_rvalid_after", 32'(ctrl_rvalid), 0);
        chk("midrst_gnt", 32'(ctrl_gnt), 1);
        sec_gnt = 0;

        // Outstanding cap of two on the second instance
        ctrl_we = 0; ctrl_addr = 32'h3000_0000; req2 = 1; sec_gnt2 = 1;
        chk("cap2_gnt0", 32'(ctrl_gnt2), 1);
        tick();
        chk("cap2_req", 32'(sec_req2), 1);
        chk("cap2_addr", sec_addr2, 32'h3000_0000);
        chk("cap2_gnt1", 32'(ctrl_gnt2), 1);
        ctrl_addr = 32'h3000_0004;
        tick();
        req2 = 0;
        chk("cap2_gnt_block", 32'(ctrl_gnt2), 0);
        tick();
        chk("cap2_req_drop", 32'(sec_req2), 0);
        chk("cap2_gnt_hold", 32'(ctrl_gnt2), 0);
        sec_gnt2 = 0;
        tick();
        chk("cap2_gnt_still", 32'(ctrl_gnt2), 0);
        sec_rvalid2 = 1; sec_rdata = 32'hA5A5_A5A5;
        tick();
        sec_rvalid2 = 0;
        chk("cap2_rvalid", 32'(ctrl_rvalid2), 1);
        chk("cap2_rdata", ctrl_rdata2, 32'hA5A5_A5A5);
        chk("cap2_gnt_release", 32'(ctrl_gnt2), 1);
        chk("cap2_we", 32'(sec_we2), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
